// File: rtl/mtrx_pkg.sv
`default_nettype none
// ============================================================================
// mtrx_pkg : shared widths, matrix-slot indices and sequencer state encoding
// Rev 1.0
// ============================================================================
package mtrx_pkg;

  localparam int ELEM_W   = 21;  // Q1.10.10 signed
  localparam int ELEMS    = 16;  // 4x4, row-major, element 0 in LSBs
  localparam int NUM_MTRX = 6;

  localparam int MTRX_IN    = 0;
  localparam int MTRX_ROTX  = 1;
  localparam int MTRX_ROTY  = 2;
  localparam int MTRX_ROTZ  = 3;
  localparam int MTRX_SHIFT = 4;
  localparam int MTRX_PROJ  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mtrx_stream_seq_next_en_idx.sv
`default_nettype none
// ============================================================================
// next_en_idx : lowest enabled mask index strictly above i_cur (i_cur = -1
//               yields the first enabled index)
// Rev 1.0
// ============================================================================
module next_en_idx #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]            i_mask,
  input  logic signed [IDX_W:0]   i_cur,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_found
);

  // Scan downwards so the lowest qualifying index is the one that sticks.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_cur))) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mtrx_stream_seq.sv
`default_nettype none
// ============================================================================
// mtrx_stream_seq : snapshots a bank of 4x4 matrices per frame and streams the
//                   enabled ones in ascending index order over valid/ready
// Rev 1.0
// ============================================================================
module mtrx_stream_seq
  import mtrx_pkg::*;
#(
  parameter int ELEM_W   = mtrx_pkg::ELEM_W,
  parameter int ELEMS    = mtrx_pkg::ELEMS,
  parameter int NUM_MTRX = mtrx_pkg::NUM_MTRX,
  parameter int IDX_W    = $clog2(NUM_MTRX)
) (
  input  logic                               CLK,
  input  logic                               rst,
  input  logic                               frame_start,
  input  logic                               abort,
  input  logic [NUM_MTRX*ELEMS*ELEM_W-1:0]   mtrx_in,
  input  logic [NUM_MTRX-1:0]                en_mask,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [ELEMS*ELEM_W-1:0]            out_data,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               out_last,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               overrun
);

  localparam int MW = ELEMS * ELEM_W;
  localparam int BW = NUM_MTRX * MW;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BW-1:0]           r_snap;
  logic [NUM_MTRX-1:0]     r_mask;
  logic                    r_valid;
  logic                    r_last;
  logic                    r_ovr;
  logic [MW-1:0]           r_data;
  logic [IDX_W-1:0]        r_idx;

  logic                    w_idle;
  logic [BW-1:0]           w_bank;
  logic [NUM_MTRX-1:0]     w_mask;
  logic signed [IDX_W:0]   w_cur;
  logic signed [IDX_W:0]   w_cur2;
  logic [IDX_W-1:0]        w_nidx;
  logic [IDX_W-1:0]        w_nidx2;
  logic                    w_found;
  logic                    w_more;
  logic [MW-1:0]           w_sel;
  logic                    w_load;
  logic                    w_clr;
  logic                    w_capture;

  // The first beat is loaded on the capture edge, so IDLE looks at the live
  // inputs while SEND walks the snapshot.
  assign w_idle = (r_state == ST_IDLE);
  assign w_bank = w_idle ? mtrx_in : r_snap;
  assign w_mask = w_idle ? en_mask : r_mask;
  assign w_cur  = w_idle ? '1 : $signed({1'b0, r_idx});
  assign w_cur2 = $signed({1'b0, w_nidx});
  assign w_sel  = w_bank[w_nidx*MW +: MW];

  next_en_idx #(.N(NUM_MTRX), .IDX_W(IDX_W)) u_find_next (
    .i_mask  (w_mask),
    .i_cur   (w_cur),
    .o_idx   (w_nidx),
    .o_found (w_found)
  );

  // Looks one step further ahead to decide out_last for the beat being loaded.
  next_en_idx #(.N(NUM_MTRX), .IDX_W(IDX_W)) u_find_after (
    .i_mask  (w_mask),
    .i_cur   (w_cur2),
    .o_idx   (w_nidx2),
    .o_found (w_more)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_capture = 1'b1;
          if (w_found) begin
            w_state_nxt = ST_SEND;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (r_valid && out_ready) begin
          if (r_last) begin
            w_state_nxt = ST_DONE;
            w_clr       = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_ovr   <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ovr   <= frame_start && !w_idle;
      if (w_capture) begin
        r_snap <= mtrx_in;
        r_mask <= en_mask;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_sel;
        r_idx   <= w_nidx;
        r_last  <= !w_more;
      end else if (w_clr) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_idx    = r_idx;
  assign out_last   = r_last;
  assign busy       = !w_idle;
  assign frame_done = (r_state == ST_DONE);
  assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_mtrx_stream_seq.sv
`default_nettype none
// ============================================================================
// tb_mtrx_stream_seq : directed + random stimulus against a queue-based model
// Rev 1.0
// ============================================================================
module tb_mtrx_stream_seq;
  import mtrx_pkg::*;

  localparam int NM = 6;
  localparam int IW = 3;
  localparam int MW = ELEMS * ELEM_W;
  localparam int BW = NM * MW;

  logic           CLK = 1'b0;
  logic           rst = 1'b1;
  logic           frame_start = 1'b0;
  logic           abort = 1'b0;
  logic           out_ready = 1'b0;
  logic [BW-1:0]  mtrx_in = '0;
  logic [NM-1:0]  en_mask = '0;
  logic           out_valid;
  logic [MW-1:0]  out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           frame_done;
  logic           overrun;

  mtrx_stream_seq #(.ELEM_W(ELEM_W), .ELEMS(ELEMS), .NUM_MTRX(NM), .IDX_W(IW)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .frame_start (frame_start),
    .abort       (abort),
    .mtrx_in     (mtrx_in),
    .en_mask     (en_mask),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a frame is just the list of enabled indices, popped on accept.
  typedef enum {M_IDLE, M_SEND, M_DONE} mmode_t;
  mmode_t        m_mode = M_IDLE;
  int            m_q[$];
  logic [MW-1:0] m_snap [NM];
  bit            m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic new_bank();
    for (int k = 0; k < BW / 32; k++) mtrx_in[k*32 +: 32] = $urandom;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (m_mode == M_SEND);
    chk("valid", {63'd0, out_valid}, {63'd0, ev});
    chk("busy", {63'd0, busy}, {63'd0, m_mode != M_IDLE});
    chk("frame_done", {63'd0, frame_done}, {63'd0, m_mode == M_DONE});
    chk("overrun", {63'd0, overrun}, {63'd0, m_ovr});
    chk("last", {63'd0, out_last}, {63'd0, ev && (m_q.size() == 1)});
    if (ev) begin
      chk("idx", 64'(out_idx), 64'(m_q[0]));
      for (int e = 0; e < ELEMS; e++)
        chk("data", 64'(out_data[e*ELEM_W +: ELEM_W]), 64'(m_snap[m_q[0]][e*ELEM_W +: ELEM_W]));
    end
  endtask

  task automatic check_zero_payload();
    chk("rst_idx", 64'(out_idx), 64'd0);
    for (int e = 0; e < ELEMS; e++)
      chk("rst_data", 64'(out_data[e*ELEM_W +: ELEM_W]), 64'd0);
  endtask

  task automatic model_step(input bit fs, input bit ab, input logic [NM-1:0] mk,
                            input bit rdy, input logic [BW-1:0] bank);
    m_ovr = fs && (m_mode != M_IDLE);
    case (m_mode)
      M_IDLE: if (fs) begin
        m_q.delete();
        for (int i = 0; i < NM; i++) begin
          m_snap[i] = bank[i*MW +: MW];
          if (mk[i]) m_q.push_back(i);
        end
        m_mode = (m_q.size() != 0) ? M_SEND : M_DONE;
      end
      M_SEND: if (ab) begin
        m_q.delete();
        m_mode = M_IDLE;
      end else if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_mode = M_DONE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Called at a negedge; drives, steps the model at posedge, checks at negedge.
  task automatic cycle(input bit fs, input bit ab, input logic [NM-1:0] mk, input bit rdy);
    frame_start = fs;
    abort       = ab;
    en_mask     = mk;
    out_ready   = rdy;
    new_bank();
    @(posedge CLK);
    model_step(fs, ab, mk, rdy, mtrx_in);
    @(negedge CLK);
    check_outputs();
  endtask

  initial begin
    bit rp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < NM; i++) m_snap[i] = '0;
    repeat (2) @(negedge CLK);
    check_outputs();
    check_zero_payload();
    rst = 1'b0;

    // all six matrices, ready held high
    cycle(1'b1, 1'b0, 6'b111111, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, NM'($urandom), 1'b1);

    // sparse mask with stalls; bank keeps changing underneath
    cycle(1'b1, 1'b0, 6'b100101, 1'b1);
    for (int j = 0; j < 5; j++) cycle(1'b0, 1'b0, NM'($urandom), rp[j]);
    repeat (3) cycle(1'b0, 1'b0, NM'($urandom), 1'b1);

    // empty mask
    cycle(1'b1, 1'b0, 6'b000000, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 6'b000000, 1'b0);

    // frame_start while sending
    cycle(1'b1, 1'b0, 6'b111111, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 6'b111111, 1'b1);
    cycle(1'b1, 1'b0, 6'b010101, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 6'b111111, 1'b1);

    // abort at idx 3 with ready high, then a clean restart
    cycle(1'b1, 1'b0, 6'b111111, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 6'b111111, 1'b1);
    cycle(1'b0, 1'b1, 6'b111111, 1'b1);
    cycle(1'b1, 1'b0, 6'b111111, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, 6'b111111, 1'b1);

    // asynchronous reset mid-frame
    cycle(1'b1, 1'b0, 6'b111111, 1'b0);
    cycle(1'b0, 1'b0, 6'b111111, 1'b1);
    rst = 1'b1;
    frame_start = 1'b0;
    abort = 1'b0;
    #1;
    m_mode = M_IDLE;
    m_q.delete();
    m_ovr = 1'b0;
    check_outputs();
    check_zero_payload();
    @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 6'b111111, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, 6'b111111, 1'b1);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      logic [NM-1:0] mk;
      mk = ($urandom_range(0, 7) == 0) ? '0 : NM'($urandom);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, mk,
            $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
